// File: rtl/uart_rx_framed.sv
// Purpose: UART receiver, 5-9 data bits, none/odd/even parity, 1-2 stop bits, 3-sample majority vote per bit.
// Latency: data_valid rises (N-1)*CLK_PER_BIT + CLK_PER_BIT/2 + 4 cycles after the pin's falling start edge.
// Backpressure: one holding register; a frame completing while it is full and not being taken is dropped with an overrun pulse.
module uart_rx_framed #(
    parameter int DATA_BIT_COUNT = 8,
    parameter int PARITY_MODE    = 0,
    parameter int STOP_BIT_COUNT = 1,
    parameter int CLK_PER_BIT    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      serial,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic [DATA_BIT_COUNT-1:0] data,
    output logic                      parity_err,
    output logic                      frame_err,
    output logic                      break_det,
    output logic                      overrun
);

    localparam int CW  = $clog2(CLK_PER_BIT);
    localparam int BW  = $clog2(DATA_BIT_COUNT + 1);
    localparam int MID = CLK_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0    = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1    = CW'(MID);
    localparam logic [CW-1:0] CNT_DEC   = CW'(MID + 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BIT_COUNT - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BIT_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic                      r_sync1;
    logic                      r_sync2;
    state_t                    r_state;
    logic [CW-1:0]             r_cnt;
    logic [BW-1:0]             r_bit_idx;
    logic [DATA_BIT_COUNT-1:0] r_shift;
    logic                      r_samp0;
    logic                      r_samp1;
    logic                      r_par_bit;
    logic                      r_ferr;
    logic                      r_data_valid;
    logic [DATA_BIT_COUNT-1:0] r_data;
    logic                      r_parity_err;
    logic                      r_frame_err;
    logic                      r_break_det;
    logic                      r_overrun;

    logic                      w_serial_s;
    logic                      w_maj;
    logic                      w_decide;
    logic [CW-1:0]             w_cnt_next;
    logic                      w_frame_err;
    logic                      w_par_xor;
    logic                      w_par_err;
    logic                      w_is_break;
    logic                      w_can_load;

    assign w_serial_s  = r_sync2;
    // Third sample is the live synchronised line in the decision cycle.
    assign w_maj       = (r_samp0 & r_samp1) | (r_samp0 & w_serial_s) | (r_samp1 & w_serial_s);
    assign w_decide    = (r_cnt == CNT_DEC);
    assign w_cnt_next  = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    // Only meaningful in the last stop-bit decision cycle.
    assign w_frame_err = r_ferr | ~w_maj;
    assign w_par_xor   = (^r_shift) ^ r_par_bit;
    assign w_par_err   = (PARITY_MODE == 1) ? ~w_par_xor :
                         (PARITY_MODE == 2) ?  w_par_xor : 1'b0;
    assign w_is_break  = w_frame_err && (r_shift == '0) && ((PARITY_MODE == 0) || !r_par_bit);
    // The holding register can take a new frame if empty or being emptied this very cycle.
    assign w_can_load  = !r_data_valid || data_ready;

    // Two-flop synchroniser for the asynchronous RX pin, idling high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial;
            r_sync2 <= r_sync1;
        end
    end

    // Frame FSM, bit sampling, and the valid/ready holding register with its flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_samp0      <= 1'b1;
            r_samp1      <= 1'b1;
            r_par_bit    <= 1'b0;
            r_ferr       <= 1'b0;
            r_data_valid <= 1'b0;
            r_data       <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break_det  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end
            if (r_cnt == CNT_S0) begin
                r_samp0 <= w_serial_s;
            end
            if (r_cnt == CNT_S1) begin
                r_samp1 <= w_serial_s;
            end
            case (r_state)
                S_IDLE: begin
                    r_bit_idx <= '0;
                    r_shift   <= '0;
                    r_ferr    <= 1'b0;
                    r_par_bit <= 1'b0;
                    // The cycle that first sees the line low is cnt = 0 of the start bit.
                    if (!w_serial_s) begin
                        r_state <= S_START;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    r_cnt <= w_cnt_next;
                    if (w_decide) begin
                        r_state <= w_maj ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    r_cnt <= w_cnt_next;
                    if (w_decide) begin
                        r_shift <= {w_maj, r_shift[DATA_BIT_COUNT-1:1]};
                        if (r_bit_idx == DATA_LAST) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    r_cnt <= w_cnt_next;
                    if (w_decide) begin
                        r_par_bit <= w_maj;
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_cnt <= w_cnt_next;
                    if (w_decide) begin
                        if (r_bit_idx == STOP_LAST) begin
                            // Commit: load overrides the plain hand-off clear above.
                            if (w_can_load) begin
                                r_data_valid <= 1'b1;
                                r_data       <= w_is_break ? '0 : r_shift;
                                r_parity_err <= w_par_err;
                                r_frame_err  <= w_frame_err;
                                r_break_det  <= w_is_break;
                            end else begin
                                r_overrun    <= 1'b1;
                            end
                            r_state <= w_frame_err ? S_WAIT_HIGH : S_IDLE;
                        end else begin
                            r_ferr    <= w_frame_err;
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    // A line stuck low yields one frame, then waits here for the line to recover.
                    if (w_serial_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_valid = r_data_valid;
    assign data       = r_data;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign break_det  = r_break_det;
    assign overrun    = r_overrun;

endmodule
